// File: rtl/request_handler.sv
// Receive-side front end of the client command path: assembles a code/address
// byte pair from the UART, validates it and offers it downstream via valid/ready.
module request_handler #(
  parameter int          TIMEOUT_CYCLES = 50_000_000,
  parameter logic [7:0]  MAX_CODE       = 8'h07,
  parameter logic [7:0]  MAX_ADDRESS    = 8'd31
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       request_ready,
  output logic       request_valid,
  output logic [7:0] request_code,
  output logic [7:0] request_address,
  output logic       busy,
  output logic       error,
  output logic [1:0] error_type,
  output logic       overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_ADDR = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;

  localparam logic [1:0] ERR_CODE    = 2'b01;
  localparam logic [1:0] ERR_ADDRESS = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    code_q, code_d;
  logic [7:0]    addr_q, addr_d;
  logic          req_valid_q, req_valid_d;
  logic [7:0]    req_code_q, req_code_d;
  logic [7:0]    req_addr_q, req_addr_d;
  logic          error_q, error_d;
  logic [1:0]    error_type_q, error_type_d;
  logic          overrun_q, overrun_d;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    code_d       = code_q;
    addr_d       = addr_q;
    req_valid_d  = req_valid_q;
    req_code_d   = req_code_q;
    req_addr_d   = req_addr_q;
    error_d      = 1'b0;
    error_type_d = error_type_q;
    overrun_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Code is checked only once the address arrives so every frame is two bytes.
        if (rx_valid) begin
          code_d  = rx_data;
          timer_d = '0;
          state_d = WAIT_ADDR;
        end
      end

      WAIT_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          timer_d = '0;
          if (code_q > MAX_CODE) begin
            error_d      = 1'b1;
            error_type_d = ERR_CODE;
            state_d      = IDLE;
          end else if (rx_data > MAX_ADDRESS) begin
            error_d      = 1'b1;
            error_type_d = ERR_ADDRESS;
            state_d      = IDLE;
          end else begin
            req_code_d  = code_q;
            req_addr_d  = rx_data;
            req_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end else if (timer_q == TIMER_LAST) begin
          error_d      = 1'b1;
          error_type_d = ERR_TIMEOUT;
          timer_d      = '0;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      HOLD: begin
        // Bytes arriving here are dropped, even on the acceptance cycle.
        if (rx_valid) overrun_d = 1'b1;
        if (request_ready) begin
          req_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        timer_d     = '0;
        req_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      code_q       <= '0;
      addr_q       <= '0;
      req_valid_q  <= 1'b0;
      req_code_q   <= '0;
      req_addr_q   <= '0;
      error_q      <= 1'b0;
      error_type_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      addr_q       <= addr_d;
      req_valid_q  <= req_valid_d;
      req_code_q   <= req_code_d;
      req_addr_q   <= req_addr_d;
      error_q      <= error_d;
      error_type_q <= error_type_d;
      overrun_q    <= overrun_d;
    end
  end

  assign request_valid   = req_valid_q;
  assign request_code    = req_code_q;
  assign request_address = req_addr_q;
  assign busy            = (state_q != IDLE);
  assign error           = error_q;
  assign error_type      = error_type_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_request_handler.sv
// Directed bench for request_handler with a 16-cycle inter-byte timeout.
module tb_request_handler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       request_ready;
  logic       request_valid;
  logic [7:0] request_code;
  logic [7:0] request_address;
  logic       busy;
  logic       error;
  logic [1:0] error_type;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  request_handler #(
    .TIMEOUT_CYCLES(16),
    .MAX_CODE      (8'h07),
    .MAX_ADDRESS   (8'd31)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .request_ready  (request_ready),
    .request_valid  (request_valid),
    .request_code   (request_code),
    .request_address(request_address),
    .busy           (busy),
    .error          (error),
    .error_type     (error_type),
    .overrun        (overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; strobes one byte across the next rising edge and
  // returns at the following negedge, where post-edge outputs are visible.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic reject(input string tag, input logic [7:0] c, input logic [7:0] a,
                        input logic [1:0] et);
    request_ready = 1'b1;
    send_byte(c);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    send_byte(a);
    chk({tag, "_err"}, {29'd0, error, error_type}, {29'd0, 1'b1, et});
    chk({tag, "_valid_busy"}, {30'd0, request_valid, busy}, 32'd0);
    @(negedge clock);
    chk({tag, "_err_off"}, {30'd0, error, request_valid}, 32'd0);
  endtask

  initial begin
    int vcnt;
    int ovcnt;
    int ecnt;
    reset_n       = 1'b0;
    rx_valid      = 1'b0;
    rx_data       = 8'h00;
    request_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outs", {request_valid, request_code, request_address, busy, error, error_type, overrun},
        32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Simple frame, ready held high.
    request_ready = 1'b1;
    send_byte(8'h03);
    chk("f1_busy", {31'd0, busy}, 32'd1);
    chk("f1_novalid", {31'd0, request_valid}, 32'd0);
    send_byte(8'h05);
    chk("f1_req", {15'd0, request_valid, request_code, request_address}, {15'd0, 1'b1, 8'h03, 8'h05});
    chk("f1_noerr", {31'd0, error}, 32'd0);
    @(negedge clock);
    chk("f1_done", {30'd0, request_valid, busy}, 32'd0);

    // Back-pressure for 10 cycles, with one overrun byte during HOLD.
    request_ready = 1'b0;
    send_byte(8'h02);
    send_byte(8'h10);
    vcnt  = 0;
    ovcnt = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (request_valid) begin
        vcnt++;
        chk("f2_stable", {16'd0, request_code, request_address}, {16'd0, 8'h02, 8'h10});
      end
      if (overrun) ovcnt++;
      request_ready = (cyc == 11);
      rx_valid      = (cyc == 4);
      rx_data       = 8'h04;
      @(negedge clock);
    end
    rx_valid      = 1'b0;
    request_ready = 1'b0;
    chk("f2_valid_cycles", vcnt, 32'd11);
    chk("f2_overrun_count", ovcnt, 32'd1);
    chk("f2_idle", {30'd0, busy, error}, 32'd0);

    send_byte(8'h01);
    send_byte(8'h00);
    chk("f3_req", {15'd0, request_valid, request_code, request_address}, {15'd0, 1'b1, 8'h01, 8'h00});
    // Byte on the acceptance cycle is dropped and must not open a frame.
    request_ready = 1'b1;
    send_byte(8'h06);
    chk("f3_accept_overrun", {29'd0, request_valid, busy, overrun}, 32'b001);
    @(negedge clock);
    chk("f3_overrun_off", {30'd0, overrun, busy}, 32'd0);

    reject("bad_code", 8'h09, 8'h05, 2'b01);
    reject("bad_addr", 8'h01, 8'h20, 2'b10);
    reject("bad_both", 8'h09, 8'h40, 2'b01);

    // Silence after the code byte: error exactly 16 cycles after entry.
    send_byte(8'h03);
    ecnt = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (error) ecnt++;
    end
    chk("to_no_early_err", ecnt, 32'd0);
    chk("to_still_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("to_err", {29'd0, error, error_type}, {29'd0, 1'b1, 2'b11});
    chk("to_idle", {30'd0, busy, request_valid}, 32'd0);
    @(negedge clock);
    chk("to_err_off", {31'd0, error}, 32'd0);

    // Address on the terminal cycle wins over the timeout.
    request_ready = 1'b1;
    send_byte(8'h03);
    repeat (15) @(negedge clock);
    send_byte(8'h05);
    chk("to_edge_req", {15'd0, request_valid, request_code, request_address},
        {15'd0, 1'b1, 8'h03, 8'h05});
    chk("to_edge_noerr", {31'd0, error}, 32'd0);
    @(negedge clock);
    chk("to_edge_done", {30'd0, request_valid, busy}, 32'd0);

    // Asynchronous reset in WAIT_ADDR (error_type is still 11 here).
    request_ready = 1'b0;
    send_byte(8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wait_outs", {request_valid, request_code, request_address, busy, error, error_type, overrun},
        32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Asynchronous reset in HOLD.
    send_byte(8'h05);
    send_byte(8'h06);
    chk("rst_hold_pre", {31'd0, request_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_hold_outs", {request_valid, request_code, request_address, busy, error, error_type, overrun},
        32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    send_byte(8'h07);
    send_byte(8'h1F);
    chk("post_rst_req", {15'd0, request_valid, request_code, request_address},
        {15'd0, 1'b1, 8'h07, 8'h1F});
    request_ready = 1'b1;
    @(negedge clock);
    chk("post_rst_done", {30'd0, request_valid, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
